// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame on the line: START(0) | DATA_BITS data bits LSB-first | even parity | STOP(1).
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   tick_os    one-clk pulse at OVERSAMPLE x baud
//   rx         asynchronous serial input, idle high
//   data_out   last received byte, held until the next valid
//   valid      one-clk strobe when a frame completes
//   parity_err parity mismatch on the frame flagged by valid
//   frame_err  stop bit sampled low on the frame flagged by valid
//   busy       high from start-bit detection until return to IDLE
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_os,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state, state_d;
    logic                 rx_meta, rx_s;
    logic [TICK_W-1:0]    tick_cnt, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 par_bad, par_bad_d;
    logic [DATA_BITS-1:0] data_out_d;
    logic                 valid_d, parity_err_d, frame_err_d, busy_d;

    // Two-flop synchroniser; reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            tick_cnt   <= tick_cnt_d;
            bit_cnt    <= bit_cnt_d;
            shift      <= shift_d;
            par_bad    <= par_bad_d;
            data_out   <= data_out_d;
            valid      <= valid_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic; everything advances only on oversample ticks.
    always_comb begin
        state_d      = state;
        tick_cnt_d   = tick_cnt;
        bit_cnt_d    = bit_cnt;
        shift_d      = shift;
        par_bad_d    = par_bad;
        data_out_d   = data_out;
        valid_d      = 1'b0;
        parity_err_d = parity_err;
        frame_err_d  = frame_err;
        busy_d       = busy;

        if (tick_os) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        busy_d     = 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        // Line back high at mid start bit means a glitch, not a frame.
                        if (rx_s) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so shifting in at the MSB leaves bit 0 in place.
                        shift_d    = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt + TICK_W'(1);
                    end
                end
                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_bad_d  = rx_s ^ (^shift);
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        data_out_d   = shift;
                        valid_d      = 1'b1;
                        parity_err_d = par_bad;
                        frame_err_d  = ~rx_s;
                        // Leaving at mid stop bit lets an immediately following start bit be caught.
                        if (rx_s) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt + TICK_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (OVERSAMPLE=16, DATA_BITS=8).
// tick_os pulses once every 3 clocks; a behavioural serialiser drives rx on tick boundaries.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk;
    logic       rst_n;
    logic       tick_os;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         vcount = 0;
    logic [7:0] cap_data [0:31];
    logic       cap_perr [0:31];
    logic       cap_ferr [0:31];

    int tick_div = 0;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_os    (tick_os),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running oversample tick, changed on the falling edge.
    initial tick_os = 1'b0;
    always @(negedge clk) begin
        tick_os = (tick_div == 0);
        tick_div = (tick_div == 2) ? 0 : tick_div + 1;
    end

    // Capture every valid strobe; a stuck valid shows up as extra captures.
    always @(negedge clk) begin
        if (valid) begin
            if (vcount < 32) begin
                cap_data[vcount] = data_out;
                cap_perr[vcount] = parity_err;
                cap_ferr[vcount] = frame_err;
            end
            vcount = vcount + 1;
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!tick_os) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 8'h00)  begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        rst_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic();
        int base;
        base = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0);
        send_bit(1'b0);
        rx = 1'b1;
        wait_ticks(7);
        checks++; if (vcount !== base) begin errors++; $display("FAIL basic_early_valid got=%0d exp=%0d", vcount, base); end
        wait_ticks(OS - 7);
        checks++; if (vcount !== base + 1) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", vcount, base + 1); end
        if (vcount == base + 1) begin
            checks++; if (cap_data[base] !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", cap_data[base]); end
            checks++; if (cap_perr[base] !== 1'b0)  begin errors++; $display("FAIL basic_perr got=%b exp=0", cap_perr[base]); end
            checks++; if (cap_ferr[base] !== 1'b0)  begin errors++; $display("FAIL basic_ferr got=%b exp=0", cap_ferr[base]); end
        end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 8'hA5)   begin errors++; $display("FAIL basic_hold got=%h exp=a5", data_out); end
        wait_ticks(4);
    endtask

    task automatic test_parity_err();
        int base;
        base = vcount;
        send_frame(8'h01, 1'b0, 1'b1);
        wait_ticks(2);
        checks++; if (vcount !== base + 1) begin errors++; $display("FAIL parity_count got=%0d exp=%0d", vcount, base + 1); end
        checks++; if (data_out !== 8'h01)  begin errors++; $display("FAIL parity_data got=%h exp=01", data_out); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_perr got=%b exp=1", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL parity_ferr got=%b exp=0", frame_err); end
    endtask

    task automatic test_frame_err();
        int base;
        base = vcount;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(OS);
        checks++; if (vcount !== base + 1) begin errors++; $display("FAIL frame_count got=%0d exp=%0d", vcount, base + 1); end
        checks++; if (data_out !== 8'h3C)  begin errors++; $display("FAIL frame_data got=%h exp=3c", data_out); end
        checks++; if (frame_err !== 1'b1)  begin errors++; $display("FAIL frame_ferr got=%b exp=1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL frame_perr got=%b exp=0", parity_err); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL frame_busy_break got=%b exp=1", busy); end
        rx = 1'b1;
        wait_ticks(4);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL frame_busy_idle got=%b exp=0", busy); end
        checks++; if (vcount !== base + 1) begin errors++; $display("FAIL frame_extra_valid got=%0d exp=%0d", vcount, base + 1); end
        wait_ticks(4);
    endtask

    task automatic test_glitch();
        int base;
        base = vcount;
        rx = 1'b0;
        wait_ticks(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(12);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL glitch_busy_low got=%b exp=0", busy); end
        wait_ticks(OS * 11);
        checks++; if (vcount !== base)     begin errors++; $display("FAIL glitch_valid got=%0d exp=%0d", vcount, base); end
        checks++; if (data_out !== 8'h3C)  begin errors++; $display("FAIL glitch_data got=%h exp=3c", data_out); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 8'h00)  begin errors++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr got=%b exp=0", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
        rx = 1'b1;
        wait_ticks(OS * 6);
        checks++; if (vcount !== base)     begin errors++; $display("FAIL rstmid_valid got=%0d exp=%0d", vcount, base); end
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(2);
        checks++; if (vcount !== base + 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=%0d", vcount, base + 1); end
        checks++; if (data_out !== 8'h5A)  begin errors++; $display("FAIL rstmid_next_data got=%h exp=5a", data_out); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_next_flags got=%b%b exp=00", parity_err, frame_err);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] exp_d [0:2];
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h80;
        base = vcount;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        wait_ticks(4);
        checks++; if (vcount !== base + 3) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", vcount, base + 3); end
        if (vcount == base + 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (cap_data[base + i] !== exp_d[i]) begin
                    errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, cap_data[base + i], exp_d[i]);
                end
                checks++; if (cap_perr[base + i] !== 1'b0 || cap_ferr[base + i] !== 1'b0) begin
                    errors++; $display("FAIL b2b_flags%0d got=%b%b exp=00", i, cap_perr[base + i], cap_ferr[base + i]);
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
